carrd_wb_commit: RTL and testbench

CARRD_WB_COMMIT -- requirements
Module: carrd_wb_commit

---
 rtl/carrd_wb_commit.sv | 212 +++++++++++++++++++++
 tb/tb_carrd_wb_commit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/carrd_wb_commit.sv
// Writeback commit queue: buffers writeback requests and drains them into the
// VRF write port (vector groups, element-0 writes) or the scalar register file.
module carrd_wb_commit #(
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned GROUP_BEATS = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         wb_valid,
  output logic         wb_ready,
  input  logic [1:0]   wb_kind,
  input  logic [4:0]   wb_vd,
  input  logic [511:0] wb_data,
  output logic         vrf_wr_en,
  output logic [4:0]   vrf_wr_addr,
  output logic [127:0] vrf_wr_data,
  output logic [15:0]  vrf_wr_mask,
  input  logic         vrf_wr_ready,
  output logic         x_wr_en,
  output logic [4:0]   x_wr_addr,
  output logic [31:0]  x_wr_data,
  input  logic [4:0]   hz_addr,
  output logic         hz_hit,
  output logic         busy
);

  localparam int unsigned DATA_W = 512;
  localparam int unsigned BEAT_W = 128;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = 16;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BCNT_W = (GROUP_BEATS > 1) ? $clog2(GROUP_BEATS) : 1;

  localparam logic [1:0] KIND_VEC   = 2'd1;
  localparam logic [1:0] KIND_X     = 2'd2;
  localparam logic [1:0] KIND_ELEM0 = 2'd3;

  typedef enum logic [1:0] {IDLE, DRAIN, SCALAR} state_t;

  typedef struct packed {
    logic [1:0]        kind;
    logic [REG_W-1:0]  vd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             fifo_q [FIFO_DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop, full, empty;

  state_t             state_q, state_d;
  logic [BCNT_W-1:0]  beat_q, beat_d;
  logic               vrf_en_d, x_en_d, busy_d;
  logic [REG_W-1:0]   vrf_addr_d, x_addr_d;
  logic [BEAT_W-1:0]  vrf_data_d;
  logic [MASK_W-1:0]  vrf_mask_d;
  logic [XLEN-1:0]    x_data_d;

  logic [PTR_W-1:0]   hz_idx;
  logic [REG_W-1:0]   hz_off;
  entry_t             hz_e;

  function automatic logic [BEAT_W-1:0] beat_slice(input logic [DATA_W-1:0] data,
                                                   input logic [BCNT_W-1:0] b);
    return BEAT_W'(data >> (BEAT_W * 32'(b)));
  endfunction

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign wb_ready = !full;
  assign push     = wb_valid && wb_ready && (wb_kind != 2'd0);
  assign head     = fifo_q[rd_ptr_q];

  // Entry stays at the head while in flight; it is only popped once fully written.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{kind: wb_kind, vd: wb_vd, data: wb_data};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Next state and next value of the registered write ports.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    pop        = 1'b0;
    vrf_en_d   = 1'b0;
    vrf_addr_d = '0;
    vrf_data_d = '0;
    vrf_mask_d = '0;
    x_en_d     = 1'b0;
    x_addr_d   = '0;
    x_data_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head.kind == KIND_VEC) begin
            state_d    = DRAIN;
            beat_d     = '0;
            vrf_en_d   = 1'b1;
            vrf_addr_d = head.vd;
            vrf_data_d = beat_slice(head.data, '0);
            vrf_mask_d = '1;
          end else if (head.kind == KIND_ELEM0) begin
            state_d    = DRAIN;
            beat_d     = '0;
            vrf_en_d   = 1'b1;
            vrf_addr_d = head.vd;
            vrf_data_d = BEAT_W'(head.data[XLEN-1:0]);
            vrf_mask_d = MASK_W'(16'h000F);
          end else if (head.kind == KIND_X) begin
            state_d  = SCALAR;
            x_en_d   = 1'b1;
            x_addr_d = head.vd;
            x_data_d = head.data[XLEN-1:0];
          end
        end
      end
      DRAIN: begin
        if (vrf_wr_ready) begin
          if (head.kind == KIND_ELEM0 || beat_q == BCNT_W'(GROUP_BEATS - 1)) begin
            pop     = 1'b1;
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d     = beat_q + BCNT_W'(1);
            vrf_en_d   = 1'b1;
            vrf_addr_d = head.vd + REG_W'(beat_d);
            vrf_data_d = beat_slice(head.data, beat_d);
            vrf_mask_d = '1;
          end
        end else begin
          vrf_en_d   = vrf_wr_en;
          vrf_addr_d = vrf_wr_addr;
          vrf_data_d = vrf_wr_data;
          vrf_mask_d = vrf_wr_mask;
        end
      end
      SCALAR: begin
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (count_d != '0) || (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      vrf_wr_en   <= 1'b0;
      vrf_wr_addr <= '0;
      vrf_wr_data <= '0;
      vrf_wr_mask <= '0;
      x_wr_en     <= 1'b0;
      x_wr_addr   <= '0;
      x_wr_data   <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      vrf_wr_en   <= vrf_en_d;
      vrf_wr_addr <= vrf_addr_d;
      vrf_wr_data <= vrf_data_d;
      vrf_wr_mask <= vrf_mask_d;
      x_wr_en     <= x_en_d;
      x_wr_addr   <= x_addr_d;
      x_wr_data   <= x_data_d;
      busy        <= busy_d;
    end
  end

  // Hazard: pending vector beats (already-written beats of the head excluded) or element-0 writes.
  always_comb begin
    hz_hit = 1'b0;
    hz_idx = '0;
    hz_off = '0;
    hz_e   = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        hz_idx = rd_ptr_q + PTR_W'(i);
        hz_e   = fifo_q[hz_idx];
        hz_off = hz_addr - hz_e.vd;
        if (hz_e.kind == KIND_VEC && 32'(hz_off) < GROUP_BEATS &&
            !(i == 0 && state_q == DRAIN && 32'(hz_off) < 32'(beat_q)))
          hz_hit = 1'b1;
        if (hz_e.kind == KIND_ELEM0 && hz_e.vd == hz_addr)
          hz_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_carrd_wb_commit.sv
// Scoreboard bench for carrd_wb_commit: each accepted request expands into its
// expected register writes; a monitor checks every presented write against them.
module tb_carrd_wb_commit;

  localparam int unsigned FIFO_DEPTH  = 2;
  localparam int unsigned GROUP_BEATS = 4;

  logic         clk = 1'b0;
  logic         nrst;
  logic         wb_valid, wb_ready;
  logic [1:0]   wb_kind;
  logic [4:0]   wb_vd;
  logic [511:0] wb_data;
  logic         vrf_wr_en, vrf_wr_ready;
  logic [4:0]   vrf_wr_addr;
  logic [127:0] vrf_wr_data;
  logic [15:0]  vrf_wr_mask;
  logic         x_wr_en;
  logic [4:0]   x_wr_addr;
  logic [31:0]  x_wr_data;
  logic [4:0]   hz_addr;
  logic         hz_hit, busy;

  carrd_wb_commit #(.FIFO_DEPTH(FIFO_DEPTH), .GROUP_BEATS(GROUP_BEATS)) dut (
    .clk(clk), .nrst(nrst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_kind(wb_kind), .wb_vd(wb_vd), .wb_data(wb_data),
    .vrf_wr_en(vrf_wr_en), .vrf_wr_addr(vrf_wr_addr), .vrf_wr_data(vrf_wr_data),
    .vrf_wr_mask(vrf_wr_mask), .vrf_wr_ready(vrf_wr_ready),
    .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_wr_data(x_wr_data),
    .hz_addr(hz_addr), .hz_hit(hz_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_x;
    logic [4:0]   addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rdy_random = 1'b0;
  bit   hz_random  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference: the list of register writes a request must eventually produce, in order.
  function automatic void model_push(input logic [1:0] kind, input logic [4:0] vd,
                                     input logic [511:0] data);
    exp_t e;
    case (kind)
      2'd1: for (int b = 0; b < GROUP_BEATS; b++) begin
        e.is_x = 1'b0;
        e.addr = 5'((32'(vd) + 32'(b)) % 32);
        e.data = data[b*128 +: 128];
        e.mask = 16'hFFFF;
        sb.push_back(e);
      end
      2'd2: begin
        e.is_x = 1'b1; e.addr = vd; e.data = 128'(data[31:0]); e.mask = 16'h0000;
        sb.push_back(e);
      end
      2'd3: begin
        e.is_x = 1'b0; e.addr = vd; e.data = 128'(data[31:0]); e.mask = 16'h000F;
        sb.push_back(e);
      end
      default: ;
    endcase
  endfunction

  function automatic bit model_hz(input logic [4:0] a);
    foreach (sb[i]) if (!sb[i].is_x && sb[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic drive_req(input logic [1:0] kind, input logic [4:0] vd, input logic [511:0] data);
    bit acc = 1'b0;
    wb_valid = 1'b1; wb_kind = kind; wb_vd = vd; wb_data = data;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = wb_ready;
      @(posedge clk);
      if (acc) model_push(kind, vd, data);
      #1;
    end
    if (!acc) chk("req_accept_timeout", 128'(0), 128'(1));
    wb_valid = 1'b0; wb_kind = 2'd0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !busy) return;
    end
    chk("drain_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_addr(input logic [4:0] a);
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      if (vrf_wr_en && vrf_wr_addr == a) return;
    end
    chk("wait_addr_timeout", 128'(0), 128'(1));
  endtask

  // Monitor: compares every presented write, plus busy/hazard, against the reference.
  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      chk("busy", 128'(busy), 128'(sb.size() != 0));
      chk("hz_hit", 128'(hz_hit), 128'(model_hz(hz_addr)));
      chk("wr_exclusive", 128'(vrf_wr_en & x_wr_en), 128'(0));
      if (!vrf_wr_en) chk("vrf_idle_zero", vrf_wr_data | 128'({vrf_wr_addr, vrf_wr_mask}), 128'(0));
      if (!x_wr_en)   chk("x_idle_zero", 128'({x_wr_addr, x_wr_data}), 128'(0));
      if (vrf_wr_en || x_wr_en) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 128'(1), 128'(0));
        end else begin
          e = sb[0];
          chk("write_port", 128'(x_wr_en), 128'(e.is_x));
          if (x_wr_en) begin
            chk("x_addr", 128'(x_wr_addr), 128'(e.addr));
            chk("x_data", 128'(x_wr_data), e.data);
            void'(sb.pop_front());
          end else begin
            chk("vrf_addr", 128'(vrf_wr_addr), 128'(e.addr));
            chk("vrf_data", vrf_wr_data, e.data);
            chk("vrf_mask", 128'(vrf_wr_mask), 128'(e.mask));
            if (vrf_wr_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_random) vrf_wr_ready = ($urandom_range(0, 3) != 0);
    if (hz_random)  hz_addr = 5'($urandom_range(0, 31));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_valid = 1'b0; wb_kind = 2'd0; wb_vd = '0; wb_data = '0;
    vrf_wr_ready = 1'b1; hz_addr = '0;
    nrst = 1'b1;
    #2 nrst = 1'b0;
    #1;
    chk("rst_vrf_en", 128'(vrf_wr_en), 128'(0));
    chk("rst_x_en", 128'(x_wr_en), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_outputs_zero", vrf_wr_data | 128'({vrf_wr_addr, vrf_wr_mask, x_wr_addr, x_wr_data}), 128'(0));
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    chk("ready_after_reset", 128'(wb_ready), 128'(1));

    // Vector group at v4: latency and consecutive beats.
    drive_req(2'd1, 5'd4, rand512());
    @(negedge clk) chk("lat_idle_cycle", 128'(vrf_wr_en), 128'(0));
    @(negedge clk) begin
      chk("lat_first_write", 128'(vrf_wr_en), 128'(1));
      chk("lat_first_addr", 128'(vrf_wr_addr), 128'(4));
    end
    wait_idle();

    // Wrapping group at v30.
    drive_req(2'd1, 5'd30, rand512());
    wait_idle();

    // Back-to-back scalar writes separated by one idle cycle.
    drive_req(2'd2, 5'd3, rand512());
    drive_req(2'd2, 5'd7, rand512());
    @(negedge clk) chk("b2b_first_x", 128'(x_wr_en), 128'(1));
    @(negedge clk) chk("b2b_idle_gap", 128'(x_wr_en), 128'(0));
    @(negedge clk) chk("b2b_second_x", 128'(x_wr_en), 128'(1));
    wait_idle();

    // Stall for three cycles on beat 2.
    drive_req(2'd1, 5'd10, rand512());
    wait_addr(5'd12);
    vrf_wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 vrf_wr_ready = 1'b1;
    wait_idle();

    // Fill the queue; third request waits for a pop.
    @(posedge clk); #1 vrf_wr_ready = 1'b0;
    drive_req(2'd1, 5'd16, rand512());
    drive_req(2'd3, 5'd17, rand512());
    @(negedge clk) chk("full_ready_low", 128'(wb_ready), 128'(0));
    @(posedge clk); #1;
    chk("full_ready_still_low", 128'(wb_ready), 128'(0));
    vrf_wr_ready = 1'b1;
    drive_req(2'd2, 5'd18, rand512());
    wait_idle();

    // Scalar then element-0 to the same index; hazard only from the element-0 write.
    hz_addr = 5'd9;
    drive_req(2'd2, 5'd9, {480'd0, 32'hDEADBEEF});
    drive_req(2'd3, 5'd9, rand512());
    @(negedge clk) chk("hz_elem0_pending", 128'(hz_hit), 128'(1));
    wait_idle();
    chk("hz_clear_after", 128'(hz_hit), 128'(0));

    // Kind 0 is dropped.
    drive_req(2'd0, 5'd9, rand512());
    repeat (3) @(posedge clk);
    #2 chk("kind0_not_busy", 128'(busy), 128'(0));

    // Reset in the middle of a group.
    @(posedge clk); #1;
    drive_req(2'd1, 5'd20, rand512());
    drive_req(2'd2, 5'd5, rand512());
    wait_addr(5'd21);
    #2 nrst = 1'b0;
    sb.delete();
    #1;
    chk("midrst_vrf_en", 128'(vrf_wr_en), 128'(0));
    chk("midrst_x_en", 128'(x_wr_en), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_zero", vrf_wr_data | 128'({vrf_wr_addr, vrf_wr_mask, x_wr_addr, x_wr_data}), 128'(0));
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    chk("midrst_ready", 128'(wb_ready), 128'(1));
    repeat (10) @(posedge clk);
    #2 chk("midrst_still_idle", 128'(busy), 128'(0));

    // Randomized traffic with random back-pressure and hazard probes.
    @(posedge clk); #1;
    rdy_random = 1'b1;
    hz_random  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive_req(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), rand512());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_random = 1'b0;
    vrf_wr_ready = 1'b1;
    wait_idle();
    chk("sb_empty_end", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
